// File: rtl/axis_write_data_strb.sv
// axis_write_data_strb
// AXI write-data engine for the stream-to-memory path. Upstream words are
// buffered in a FIFO, packed RATIO words per AXI beat (first word in the low
// lane), given byte strobes, zero-padded in a short final beat, and marked
// with wlast at every burst boundary and on the final beat.
//
// state  | meaning
// IDLE   | waiting for cfg_valid; cfg_ready high
// ACTIVE | accepting words, packing and issuing beats
// DONE   | one-cycle done pulse, then back to IDLE
module axis_write_data_strb #(
    parameter int BUF_AWIDTH     = 9,
    parameter int CONFIG_DWIDTH  = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int AXI_DATA_WIDTH = 64,
    parameter int AXI_LEN_WIDTH  = 8
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [CONFIG_DWIDTH-1:0]    cfg_length,
    input  logic [AXI_LEN_WIDTH-1:0]    cfg_burst,
    input  logic                        cfg_valid,
    output logic                        cfg_ready,
    output logic                        done,
    output logic [AXI_DATA_WIDTH-1:0]   axi_wdata,
    output logic [AXI_DATA_WIDTH/8-1:0] axi_wstrb,
    output logic                        axi_wlast,
    output logic                        axi_wvalid,
    input  logic                        axi_wready,
    input  logic [DATA_WIDTH-1:0]       data,
    input  logic                        valid,
    output logic                        ready
);

    localparam int RATIO  = AXI_DATA_WIDTH / DATA_WIDTH;
    localparam int LOG2R  = $clog2(RATIO);
    localparam int LANE_W = (LOG2R > 0) ? LOG2R : 1;
    localparam int BPW    = DATA_WIDTH / 8;
    localparam int STRB_W = AXI_DATA_WIDTH / 8;
    localparam int DEPTH  = 2 ** BUF_AWIDTH;
    localparam int HALF   = DEPTH / 2;

    localparam logic [2:0] S_IDLE   = 3'b001;
    localparam logic [2:0] S_ACTIVE = 3'b010;
    localparam logic [2:0] S_DONE   = 3'b100;

    logic [2:0]                state;
    logic [2:0]                state_nx;

    logic [CONFIG_DWIDTH-1:0]  len_q;
    logic [CONFIG_DWIDTH-1:0]  beats_q;
    logic [AXI_LEN_WIDTH-1:0]  burst_q;
    logic [CONFIG_DWIDTH-1:0]  cfg_rem;
    logic [CONFIG_DWIDTH-1:0]  cfg_beats;

    logic [CONFIG_DWIDTH-1:0]  in_cnt;
    logic [CONFIG_DWIDTH-1:0]  pop_cnt;
    logic [CONFIG_DWIDTH-1:0]  beat_cnt;
    logic [CONFIG_DWIDTH-1:0]  beat_cnt_nx;
    logic [AXI_LEN_WIDTH-1:0]  burst_cnt;
    logic [AXI_LEN_WIDTH-1:0]  burst_cnt_nx;

    logic [DATA_WIDTH-1:0]     mem [DEPTH];
    logic [BUF_AWIDTH-1:0]     wr_ptr;
    logic [BUF_AWIDTH-1:0]     rd_ptr;
    logic [BUF_AWIDTH:0]       fifo_cnt;
    logic [DATA_WIDTH-1:0]     pop_data;

    logic [LANE_W-1:0]         lane;
    logic [AXI_DATA_WIDTH-1:0] lane_data;
    logic [STRB_W-1:0]         lane_strb;

    logic start;
    logic push;
    logic pop;
    logic hs;
    logic last_hs;
    logic beat_end;
    logic wlast_new;

    // Beat count rounds up; the remainder marks a partially filled last beat.
    assign cfg_rem   = cfg_length & CONFIG_DWIDTH'(RATIO - 1);
    assign cfg_beats = (cfg_length >> LOG2R) + CONFIG_DWIDTH'(cfg_rem != '0);

    assign start    = (state == S_IDLE) & cfg_valid;
    assign push     = valid & ready;
    assign hs       = axi_wvalid & axi_wready;
    // A pop needs the output register free now or freed by this cycle's handshake.
    assign pop      = (state == S_ACTIVE) & (fifo_cnt != '0)
                      & (~axi_wvalid | axi_wready) & (pop_cnt < len_q);
    assign last_hs  = hs & (beat_cnt == beats_q - CONFIG_DWIDTH'(1));
    assign beat_end = (lane == LANE_W'(RATIO - 1))
                      | (pop_cnt == len_q - CONFIG_DWIDTH'(1));
    assign pop_data = mem[rd_ptr];

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state logic
    always_comb begin
        state_nx = S_IDLE;
        unique case (state)
            S_IDLE: begin
                if (start) begin
                    state_nx = (cfg_length == '0) ? S_DONE : S_ACTIVE;
                end else begin
                    state_nx = S_IDLE;
                end
            end
            S_ACTIVE: state_nx = last_hs ? S_DONE : S_ACTIVE;
            S_DONE:   state_nx = S_IDLE;
            default:  state_nx = S_IDLE;
        endcase
    end

    // FSM-decoded outputs; upstream is throttled at half depth so it never overflows
    always_comb begin
        cfg_ready = (state == S_IDLE);
        done      = (state == S_DONE);
        ready     = (state == S_ACTIVE) & (in_cnt < len_q)
                    & (fifo_cnt < (BUF_AWIDTH + 1)'(HALF));
    end

    // Lane placement and burst/beat bookkeeping as seen after this cycle's handshake
    always_comb begin
        lane_data    = AXI_DATA_WIDTH'(pop_data) << (int'(lane) * DATA_WIDTH);
        lane_strb    = STRB_W'({BPW{1'b1}}) << (int'(lane) * BPW);
        beat_cnt_nx  = beat_cnt + CONFIG_DWIDTH'(hs);
        burst_cnt_nx = burst_cnt;
        if (hs) begin
            burst_cnt_nx = axi_wlast ? '0 : burst_cnt + AXI_LEN_WIDTH'(1);
        end
        wlast_new = (burst_cnt_nx == burst_q)
                    | (beat_cnt_nx == beats_q - CONFIG_DWIDTH'(1));
    end

    // Configuration capture
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            len_q   <= '0;
            beats_q <= '0;
            burst_q <= '0;
        end else if (start) begin
            len_q   <= cfg_length;
            beats_q <= cfg_beats;
            burst_q <= cfg_burst;
        end
    end

    // FIFO storage (no reset needed; validity is tracked by the pointers)
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= data;
        end
    end

    // FIFO pointers, occupancy and word counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
            in_cnt   <= '0;
            pop_cnt  <= '0;
        end else if (start) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
            in_cnt   <= '0;
            pop_cnt  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + BUF_AWIDTH'(1);
                in_cnt <= in_cnt + CONFIG_DWIDTH'(1);
            end
            if (pop) begin
                rd_ptr  <= rd_ptr + BUF_AWIDTH'(1);
                pop_cnt <= pop_cnt + CONFIG_DWIDTH'(1);
            end
            unique case ({push, pop})
                2'b10:   fifo_cnt <= fifo_cnt + (BUF_AWIDTH + 1)'(1);
                2'b01:   fifo_cnt <= fifo_cnt - (BUF_AWIDTH + 1)'(1);
                default: fifo_cnt <= fifo_cnt;
            endcase
        end
    end

    // Beat assembly directly in the output registers; lane 0 clears stale lanes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            axi_wdata  <= '0;
            axi_wstrb  <= '0;
            axi_wlast  <= 1'b0;
            axi_wvalid <= 1'b0;
            lane       <= '0;
            beat_cnt   <= '0;
            burst_cnt  <= '0;
        end else if (start) begin
            axi_wlast  <= 1'b0;
            axi_wvalid <= 1'b0;
            lane       <= '0;
            beat_cnt   <= '0;
            burst_cnt  <= '0;
        end else begin
            beat_cnt  <= beat_cnt_nx;
            burst_cnt <= burst_cnt_nx;
            if (hs) begin
                axi_wvalid <= 1'b0;
            end
            if (pop) begin
                if (lane == '0) begin
                    axi_wdata <= lane_data;
                    axi_wstrb <= lane_strb;
                end else begin
                    axi_wdata <= axi_wdata | lane_data;
                    axi_wstrb <= axi_wstrb | lane_strb;
                end
                if (beat_end) begin
                    axi_wvalid <= 1'b1;
                    axi_wlast  <= wlast_new;
                    lane       <= '0;
                end else begin
                    lane <= lane + LANE_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_axis_write_data_strb.sv
// Bench for axis_write_data_strb (default parameters: RATIO=2, 512-word FIFO).
// Expected beats are built from the word list at configuration time and
// queued; a negedge monitor pops and compares on every handshake.
module tb_axis_write_data_strb;

    localparam int DW = 32;
    localparam int AW = 64;
    localparam int R  = AW / DW;

    typedef struct {
        logic [AW-1:0]   d;
        logic [AW/8-1:0] s;
        logic            l;
        logic            f;
    } beat_t;

    logic          clk;
    logic          rst_n;
    logic [31:0]   cfg_length;
    logic [7:0]    cfg_burst;
    logic          cfg_valid;
    logic          cfg_ready;
    logic          done;
    logic [AW-1:0] axi_wdata;
    logic [7:0]    axi_wstrb;
    logic          axi_wlast;
    logic          axi_wvalid;
    logic          axi_wready;
    logic [DW-1:0] data;
    logic          valid;
    logic          ready;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int exp_done_cyc = -10;
    int hs_cnt = 0;
    int sent = 0;
    int wr_mode = 0;

    beat_t         sb[$];
    logic [DW-1:0] in_words[$];

    logic          prev_stall;
    logic [AW-1:0] prev_d;
    logic [7:0]    prev_s;
    logic          prev_l;

    axis_write_data_strb dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cfg_length (cfg_length),
        .cfg_burst  (cfg_burst),
        .cfg_valid  (cfg_valid),
        .cfg_ready  (cfg_ready),
        .done       (done),
        .axi_wdata  (axi_wdata),
        .axi_wstrb  (axi_wstrb),
        .axi_wlast  (axi_wlast),
        .axi_wvalid (axi_wvalid),
        .axi_wready (axi_wready),
        .data       (data),
        .valid      (valid),
        .ready      (ready)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Slave ready: 0 = always ready, 1 = random, 2 = held low
    initial begin
        axi_wready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (wr_mode)
                0:       axi_wready = 1'b1;
                1:       axi_wready = 1'($urandom_range(1));
                default: axi_wready = 1'b0;
            endcase
        end
    end

    // Monitor: scoreboard compare, hold-while-stalled, done timing
    initial begin
        beat_t e;
        prev_stall = 1'b0;
        prev_d = '0;
        prev_s = '0;
        prev_l = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_stall = 1'b0;
            end else begin
                if (prev_stall) begin
                    chk("hold_valid", 64'(axi_wvalid), 64'(1'b1));
                    chk("hold_data", axi_wdata, prev_d);
                    chk("hold_strb", 64'(axi_wstrb), 64'(prev_s));
                    chk("hold_last", 64'(axi_wlast), 64'(prev_l));
                end
                if (axi_wvalid && axi_wready) begin
                    hs_cnt++;
                    if (sb.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL unexpected_beat: got data 0x%0h with no beat expected at %0t",
                                 axi_wdata, $time);
                    end else begin
                        e = sb.pop_front();
                        chk("beat_data", axi_wdata, e.d);
                        chk("beat_strb", 64'(axi_wstrb), 64'(e.s));
                        chk("beat_last", 64'(axi_wlast), 64'(e.l));
                        if (e.f) exp_done_cyc = cyc + 1;
                    end
                end
                if (done || cyc == exp_done_cyc) begin
                    chk("done_timing", 64'(done), 64'(cyc == exp_done_cyc));
                end
                prev_stall = axi_wvalid && !axi_wready;
                prev_d = axi_wdata;
                prev_s = axi_wstrb;
                prev_l = axi_wlast;
            end
        end
    end

    task automatic check_reset_outputs();
        chk("rst_cfg_ready", 64'(cfg_ready), 64'(1'b1));
        chk("rst_done", 64'(done), 64'(1'b0));
        chk("rst_ready", 64'(ready), 64'(1'b0));
        chk("rst_wvalid", 64'(axi_wvalid), 64'(1'b0));
        chk("rst_wlast", 64'(axi_wlast), 64'(1'b0));
        chk("rst_wdata", axi_wdata, 64'(0));
        chk("rst_wstrb", 64'(axi_wstrb), 64'(0));
    endtask

    // Build the expected beats from the packing rules, then issue the configuration
    task automatic start_cfg(input int len, input int burst);
        int    nbeats;
        int    guard;
        beat_t b;
        guard = 0;
        @(negedge clk);
        while (!cfg_ready && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        chk("cfg_ready_wait", 64'(cfg_ready), 64'(1'b1));
        in_words.delete();
        sent = 0;
        for (int i = 0; i < len; i++) in_words.push_back($urandom);
        nbeats = (len + R - 1) / R;
        for (int k = 0; k < nbeats; k++) begin
            b.d = '0;
            b.s = '0;
            for (int l = 0; l < R; l++) begin
                if (k * R + l < len) begin
                    b.d[l*DW +: DW]     = in_words[k*R+l];
                    b.s[l*(DW/8) +: DW/8] = '1;
                end
            end
            b.l = ((k % (burst + 1)) == burst) || (k == nbeats - 1);
            b.f = (k == nbeats - 1);
            sb.push_back(b);
        end
        @(posedge clk);
        #1;
        cfg_valid  = 1'b1;
        cfg_length = 32'(len);
        cfg_burst  = 8'(burst);
        if (len == 0) exp_done_cyc = cyc + 1;
        @(posedge clk);
        #1;
        cfg_valid = 1'b0;
        @(negedge clk);
        chk("ready_after_cfg", 64'(ready), 64'(len > 0));
    endtask

    task automatic feed(input int limit, input int prob);
        int guard;
        guard = 0;
        while (sent < limit && guard < 20000) begin
            @(posedge clk);
            #1;
            valid = ($urandom_range(99) < prob);
            data  = valid ? in_words[sent] : $urandom;
            @(negedge clk);
            if (valid && ready) sent++;
            guard++;
        end
        chk("feed_complete", 64'(sent >= limit), 64'(1'b1));
        @(posedge clk);
        #1;
        valid = 1'b0;
    endtask

    // Keep offering extra words while waiting; none may be taken
    task automatic wait_done();
        int guard;
        int junk;
        guard = 0;
        junk = 0;
        @(posedge clk);
        #1;
        valid = 1'b1;
        data  = $urandom;
        do begin
            @(negedge clk);
            if (ready) junk++;
            guard++;
        end while (!done && guard < 5000);
        chk("done_seen", 64'(done), 64'(1'b1));
        chk("extra_words_accepted", 64'(junk), 64'(0));
        @(posedge clk);
        #1;
        valid = 1'b0;
        @(negedge clk);
        chk("cfg_ready_after_done", 64'(cfg_ready), 64'(1'b1));
        chk("sb_empty", 64'(sb.size()), 64'(0));
    endtask

    task automatic run_xfer(input int len, input int burst, input int prob);
        start_cfg(len, burst);
        feed(len, prob);
        wait_done();
    endtask

    initial begin
        int h0;
        rst_n      = 1'b0;
        valid      = 1'b0;
        data       = '0;
        cfg_valid  = 1'b0;
        cfg_length = '0;
        cfg_burst  = '0;
        wr_mode    = 0;
        repeat (3) @(negedge clk);
        check_reset_outputs();
        rst_n = 1'b1;

        // Full beats, two beats per burst
        h0 = hs_cnt;
        run_xfer(8, 1, 100);
        chk("len8_beats", 64'(hs_cnt - h0), 64'(4));

        // Odd length: last beat half filled, single burst
        h0 = hs_cnt;
        run_xfer(5, 255, 100);
        chk("len5_beats", 64'(hs_cnt - h0), 64'(3));

        // Zero length: done only, no beats
        h0 = hs_cnt;
        start_cfg(0, 3);
        @(negedge clk);
        chk("len0_cfg_ready", 64'(cfg_ready), 64'(1'b1));
        chk("len0_beats", 64'(hs_cnt - h0), 64'(0));

        // Long transfer with random backpressure
        wr_mode = 1;
        h0 = hs_cnt;
        run_xfer(1000, 15, 80);
        chk("len1000_beats", 64'(hs_cnt - h0), 64'(500));

        // Random lengths and bursts
        for (int i = 0; i < 6; i++) begin
            run_xfer($urandom_range(200, 1), $urandom_range(7), $urandom_range(100, 30));
        end
        run_xfer(1, 0, 100);

        // Long stall: 256 words buffered plus one packed beat of R words held
        wr_mode = 2;
        start_cfg(400, 15);
        fork
            feed(400, 100);
            begin
                repeat (600) @(negedge clk);
                chk("stall_accepted", 64'(sent), 64'(256 + R));
                chk("stall_ready_low", 64'(ready), 64'(1'b0));
                wr_mode = 1;
            end
        join
        wait_done();

        // Reset in the middle of a stalled burst
        wr_mode = 2;
        start_cfg(100, 3);
        feed(40, 100);
        repeat (5) @(negedge clk);
        chk("stall_wvalid", 64'(axi_wvalid), 64'(1'b1));
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs();
        sb.delete();
        exp_done_cyc = -10;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        wr_mode = 1;
        h0 = hs_cnt;
        run_xfer(21, 2, 90);
        chk("post_reset_beats", 64'(hs_cnt - h0), 64'(11));

        repeat (5) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
